// File: rtl/spi_slave_seq.sv
// Byte sequencer for spi_slave: feeds TX bytes, captures RX bytes, tracks frames on ssn.
// Host side sees show-ahead TX/RX FIFOs, sticky error flags and a per-frame byte count.
module spi_slave_seq #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] FILL_BYTE  = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_en,
    input  logic       cfg_cpol,
    input  logic       cfg_cpha,
    input  logic [7:0] tx_wdata,
    input  logic       tx_wr,
    output logic       tx_full,
    output logic [7:0] rx_rdata,
    input  logic       rx_rd,
    output logic       rx_empty,
    input  logic       clr_flags,
    output logic       tx_underrun,
    output logic       rx_overrun,
    output logic       frame_done,
    output logic [7:0] frame_len,
    input  logic       ssn,
    input  logic       tr_done_s,
    input  logic [7:0] data_r_s,
    output logic [7:0] data_s,
    output logic [7:0] spcon_s
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_END} state_t;

    state_t      state, state_nxt;
    logic        ssn_m, ssn_s;
    logic        cur_valid;
    logic [7:0]  cnt, cnt_nxt;
    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [7:0]  rx_mem [FIFO_DEPTH];
    logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic        tx_empty, rx_full;
    logic        en_l, tr;
    logic        tx_push, tx_pop, rx_push, rx_pop, rx_drop;
    logic [7:0]  tx_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ssn_m <= 1'b1;
            ssn_s <= 1'b1;
        end else begin
            ssn_m <= ssn;
            ssn_s <= ssn_m;
        end
    end

    // Enable is the copy latched into spcon_s, so it is frozen for the whole frame.
    assign en_l = spcon_s[0];
    assign tr   = tr_done_s && (state == ST_ACTIVE) && en_l;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        case (state)
            ST_IDLE:   if (!ssn_s && en_l) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (ssn_s) state_nxt = ST_END;
            ST_END: begin
                frame_done = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
    assign tx_head  = tx_mem[tx_rp[AW-1:0]];
    assign rx_rdata = rx_empty ? 8'h00 : rx_mem[rx_rp[AW-1:0]];

    assign tx_push = tx_wr && !tx_full;
    assign tx_pop  = !tx_empty && (((state == ST_IDLE) && !cur_valid) || tr);
    // A pop on a full RX frees the slot the same cycle, so the push still lands.
    assign rx_pop  = rx_rd && !rx_empty;
    assign rx_push = tr && (!rx_full || rx_rd);
    assign rx_drop = tr && rx_full && !rx_rd;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= tx_wdata;
        if (rx_push) rx_mem[rx_wp[AW-1:0]] <= data_r_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PTR_ONE;
            if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
            if (rx_push) rx_wp <= rx_wp + PTR_ONE;
            if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
        end
    end

    always_comb begin
        cnt_nxt = cnt;
        if ((state == ST_IDLE) && (state_nxt == ST_ACTIVE)) cnt_nxt = 8'd0;
        else if (tr && (cnt != 8'hFF))                       cnt_nxt = cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_s      <= FILL_BYTE;
            cur_valid   <= 1'b0;
            spcon_s     <= 8'h00;
            tx_underrun <= 1'b0;
            rx_overrun  <= 1'b0;
            cnt         <= 8'd0;
            frame_len   <= 8'd0;
        end else begin
            cnt <= cnt_nxt;
            if (state == ST_IDLE) spcon_s <= {5'b0, cfg_cpol, cfg_cpha, cfg_en};
            if (tr) begin
                data_s    <= tx_empty ? FILL_BYTE : tx_head;
                cur_valid <= !tx_empty;
            end else if (tx_pop) begin
                data_s    <= tx_head;
                cur_valid <= 1'b1;
            end
            if (tr && !cur_valid) tx_underrun <= 1'b1;
            else if (clr_flags)   tx_underrun <= 1'b0;
            if (rx_drop)          rx_overrun  <= 1'b1;
            else if (clr_flags)   rx_overrun  <= 1'b0;
            // Capture the post-update count so a byte finishing on the exit cycle is included.
            if ((state == ST_ACTIVE) && (state_nxt == ST_END)) frame_len <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_spi_slave_seq.sv
// Bench for spi_slave_seq: queue-based behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized frames.
module tb_spi_slave_seq;
    localparam int         D  = 4;
    localparam logic [7:0] FB = 8'hFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_en = 1'b0, cfg_cpol = 1'b0, cfg_cpha = 1'b0;
    logic [7:0] tx_wdata = 8'h00;
    logic       tx_wr = 1'b0;
    logic       tx_full;
    logic [7:0] rx_rdata;
    logic       rx_rd = 1'b0;
    logic       rx_empty;
    logic       clr_flags = 1'b0;
    logic       tx_underrun, rx_overrun, frame_done;
    logic [7:0] frame_len;
    logic       ssn = 1'b1;
    logic       tr_done_s = 1'b0;
    logic [7:0] data_r_s = 8'h00;
    logic [7:0] data_s, spcon_s;

    always #5 clk = ~clk;

    spi_slave_seq #(.FIFO_DEPTH(D), .FILL_BYTE(FB)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
        .tx_wdata(tx_wdata), .tx_wr(tx_wr), .tx_full(tx_full), .rx_rdata(rx_rdata),
        .rx_rd(rx_rd), .rx_empty(rx_empty), .clr_flags(clr_flags),
        .tx_underrun(tx_underrun), .rx_overrun(rx_overrun), .frame_done(frame_done),
        .frame_len(frame_len), .ssn(ssn), .tr_done_s(tr_done_s), .data_r_s(data_r_s),
        .data_s(data_s), .spcon_s(spcon_s)
    );

    int total = 0;
    int bad = 0;
    int fd_seen = 0;
    bit rnd = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_s1, m_s2, m_cv, m_und, m_ovr, m_fd;
    int         m_ph;          // 0 idle, 1 in frame, 2 frame end
    logic [7:0] m_data, m_spcon, m_cnt, m_flen;
    logic [7:0] txq[$];
    logic [7:0] rxq[$];

    function automatic void m_reset();
        m_s1 = 1; m_s2 = 1; m_ph = 0; m_cv = 0; m_und = 0; m_ovr = 0; m_fd = 0;
        m_data = FB; m_spcon = 8'h00; m_cnt = 0; m_flen = 0;
        txq.delete(); rxq.delete();
    endfunction

    function automatic void m_step();
        int         ph   = m_ph;
        bit         s2   = m_s2;
        bit         en   = m_spcon[0];
        bit         tr   = tr_done_s && (ph == 1) && en;
        bit         txe  = (txq.size() == 0);
        bit         txf  = (txq.size() == D);
        bit         pop  = !txe && ((ph == 0 && !m_cv) || tr);
        logic [7:0] hd   = txe ? FB : txq[0];
        bit         drop = tr && (rxq.size() == D) && !rx_rd;
        bit         set_u = tr && !m_cv;
        if (pop) void'(txq.pop_front());
        if (tx_wr && !txf) txq.push_back(tx_wdata);
        if (tr) begin m_data = hd; m_cv = !txe; end
        else if (pop) begin m_data = hd; m_cv = 1; end
        m_und = set_u ? 1'b1 : (clr_flags ? 1'b0 : m_und);
        m_ovr = drop  ? 1'b1 : (clr_flags ? 1'b0 : m_ovr);
        if (!drop) begin
            if (rx_rd && rxq.size() > 0) void'(rxq.pop_front());
            if (tr) rxq.push_back(data_r_s);
        end
        if (ph == 0 && !s2 && en) m_cnt = 0;
        if (tr && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        if (ph == 1 && s2) m_flen = m_cnt;
        case (ph)
            0: if (!s2 && en) m_ph = 1;
            1: if (s2) m_ph = 2;
            default: m_ph = 0;
        endcase
        if (ph == 0) m_spcon = {5'b0, cfg_cpol, cfg_cpha, cfg_en};
        m_s2 = m_s1;
        m_s1 = ssn;
        m_fd = (m_ph == 2);
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else        m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("data_s", data_s, m_data);
            chk("spcon_s", spcon_s, m_spcon);
            chk("tx_full", tx_full, txq.size() == D);
            chk("rx_empty", rx_empty, rxq.size() == 0);
            if (rxq.size() > 0) chk("rx_rdata", rx_rdata, rxq[0]);
            chk("tx_underrun", tx_underrun, m_und);
            chk("rx_overrun", rx_overrun, m_ovr);
            chk("frame_done", frame_done, m_fd);
            chk("frame_len", frame_len, m_flen);
            if (frame_done === 1'b1) fd_seen++;
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] fv [300];
    logic [7:0] log_d [300];
    logic       log_u [300];
    logic       log_o [300];
    logic [7:0] log_sp;

    task automatic side();
        tx_wr     = ($urandom % 4) == 0;
        tx_wdata  = 8'($urandom);
        rx_rd     = ($urandom % 3) == 0;
        clr_flags = ($urandom % 10) == 0;
    endtask

    task automatic cyc();
        @(negedge clk);
        if (rnd) side();
    endtask

    task automatic txw(input logic [7:0] b);
        tx_wr = 1'b1; tx_wdata = b; cyc(); tx_wr = 1'b0;
    endtask

    task automatic rxp(input string nm, input logic [7:0] exp);
        chk(nm, rx_rdata, exp);
        rx_rd = 1'b1; cyc(); rx_rd = 1'b0;
    endtask

    task automatic clr_pulse();
        clr_flags = 1'b1; cyc(); clr_flags = 1'b0; cyc();
    endtask

    task automatic frame(input int n, input int gap, input bit rd_last, input bit clr_tr,
                         input bit mid_cfg);
        ssn = 1'b0;
        repeat (4) cyc();
        log_d[0] = data_s;
        for (int i = 0; i < n; i++) begin
            repeat (gap) cyc();
            tr_done_s = 1'b1;
            data_r_s  = fv[i];
            if (rd_last && i == n - 1) rx_rd = 1'b1;
            if (clr_tr) clr_flags = 1'b1;
            if (mid_cfg && i == 0) begin cfg_cpol = 1'b1; cfg_cpha = 1'b1; end
            cyc();
            tr_done_s = 1'b0;
            if (rd_last) rx_rd = 1'b0;
            if (clr_tr) clr_flags = 1'b0;
            log_d[i+1] = data_s;
            log_u[i+1] = tx_underrun;
            log_o[i+1] = rx_overrun;
            log_sp     = spcon_s;
        end
        cyc();
        ssn = 1'b1;
        repeat (6) cyc();
    endtask

    initial begin
        int fds;
        repeat (2) @(negedge clk);
        chk("rst data_s", data_s, 8'hFF);
        chk("rst spcon_s", spcon_s, 8'h00);
        chk("rst rx_empty", rx_empty, 1);
        rst_n = 1'b1;
        cfg_en = 1'b1;
        repeat (2) cyc();

        // basic two-byte frame
        txw(8'hA5); txw(8'h3C); repeat (2) cyc();
        fv[0] = 8'h11; fv[1] = 8'h22;
        frame(2, 2, 0, 0, 0);
        chk("basic frame_len", frame_len, 2);
        chk("basic frame_done count", fd_seen, 1);
        chk("basic spcon", log_sp, 8'h01);
        chk("basic data_s fill", data_s, 8'hFF);
        chk("basic underrun", tx_underrun, 0);
        chk("basic overrun", rx_overrun, 0);
        rxp("basic rx0", 8'h11);
        rxp("basic rx1", 8'h22);
        chk("basic rx drained", rx_empty, 1);

        // underrun
        txw(8'h5A); repeat (2) cyc();
        fv[0] = 8'h01; fv[1] = 8'h02; fv[2] = 8'h03;
        frame(3, 2, 0, 0, 0);
        chk("und data0", log_d[0], 8'h5A);
        chk("und data1", log_d[1], 8'hFF);
        chk("und data2", log_d[2], 8'hFF);
        chk("und flag after1", log_u[1], 0);
        chk("und flag after2", log_u[2], 1);
        chk("und frame_len", frame_len, 3);
        rxp("und rx0", 8'h01); rxp("und rx1", 8'h02); rxp("und rx2", 8'h03);
        clr_pulse();
        chk("und cleared", tx_underrun, 0);

        // overrun
        for (int i = 0; i < 5; i++) fv[i] = 8'h31 + 8'(i);
        frame(5, 1, 0, 0, 0);
        chk("ovr after4", log_o[4], 0);
        chk("ovr after5", log_o[5], 1);
        for (int i = 0; i < 4; i++) rxp("ovr rx", 8'h31 + 8'(i));
        chk("ovr rx drained", rx_empty, 1);
        clr_pulse();
        chk("ovr cleared", rx_overrun, 0);

        // config freeze
        fv[0] = 8'h99;
        frame(1, 1, 0, 0, 1);
        chk("freeze in frame", log_sp, 8'h01);
        chk("freeze after", spcon_s, 8'h07);
        cfg_cpol = 1'b0; cfg_cpha = 1'b0; repeat (2) cyc();
        rxp("freeze rx", 8'h99);
        clr_pulse();

        // RX full with simultaneous pop and push
        for (int i = 0; i < 4; i++) fv[i] = 8'h41 + 8'(i);
        frame(4, 1, 0, 0, 0);
        fv[0] = 8'h45;
        frame(1, 1, 1, 0, 0);
        chk("sim no overrun", log_o[1], 0);
        for (int i = 0; i < 4; i++) rxp("sim rx", 8'h42 + 8'(i));
        chk("sim count 4", rx_empty, 1);
        clr_pulse();

        // clr_flags loses to a same-cycle underrun
        chk("clr pre", tx_underrun, 0);
        fv[0] = 8'h51;
        frame(1, 1, 0, 1, 0);
        chk("clr vs set", log_u[1], 1);
        rxp("clr rx", 8'h51);
        clr_pulse();

        // byte count saturates
        for (int i = 0; i < 300; i++) fv[i] = 8'($urandom);
        frame(257, 0, 0, 0, 0);
        chk("sat frame_len", frame_len, 8'hFF);
        for (int i = 0; i < 4; i++) rxp("sat rx", fv[i]);
        clr_pulse();

        // asynchronous reset mid-byte
        txw(8'h77); txw(8'h78); cyc();
        ssn = 1'b0; repeat (4) cyc();
        tr_done_s = 1'b1; data_r_s = 8'h66; cyc(); tr_done_s = 1'b0; cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("arst data_s", data_s, 8'hFF);
        chk("arst spcon_s", spcon_s, 8'h00);
        chk("arst tx_full", tx_full, 0);
        chk("arst rx_empty", rx_empty, 1);
        chk("arst rx_rdata", rx_rdata, 8'h00);
        chk("arst underrun", tx_underrun, 0);
        chk("arst overrun", rx_overrun, 0);
        chk("arst frame_done", frame_done, 0);
        chk("arst frame_len", frame_len, 8'h00);
        ssn = 1'b1;
        repeat (2) cyc();
        rst_n = 1'b1;
        fds = fd_seen;
        repeat (10) cyc();
        chk("arst no frame_done", fd_seen, fds);
        chk("arst tx emptied", data_s, 8'hFF);

        // randomized frames
        rnd = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cfg_en   = ($urandom % 8) != 0;
            cfg_cpol = 1'($urandom);
            cfg_cpha = 1'($urandom);
            repeat ($urandom_range(2, 6)) cyc();
            if (($urandom % 3) == 0) begin
                tr_done_s = 1'b1; data_r_s = 8'($urandom); cyc(); tr_done_s = 1'b0;
            end
            for (int i = 0; i < 8; i++) fv[i] = 8'($urandom);
            frame($urandom_range(1, 7), $urandom_range(0, 3), 0, 0, 0);
        end
        rnd = 1'b0;
        tx_wr = 1'b0; rx_rd = 1'b0; clr_flags = 1'b0;
        repeat (4) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_seq.md
# spi_slave_seq

Byte sequencer for `spi_slave`. It feeds transmit bytes to the engine's `data_s`, drives `spcon_s`, and captures each received `data_r_s` on `tr_done_s`. It tracks frames using `ssn`. Host logic sees two small show-ahead FIFOs (TX and RX), sticky error flags and a per-frame byte count, so multi-byte SPI frames run without per-byte host intervention.

## Interface
- `FIFO_DEPTH`, 4: entries per FIFO; power of two, minimum 2.
- `FILL_BYTE`, 8'hFF: byte driven on `data_s` when no TX data is available.
- `clk` input 1: system clock. The one clock; it is also `spi_slave`'s `clk`.
- `rst_n` input 1: asynchronous reset, active-low.
- `cfg_en` input 1: sequencer enable.
- `cfg_cpol` input 1: clock polarity for `spcon_s`.
- `cfg_cpha` input 1: clock phase for `spcon_s`.
- `tx_wdata` input 8: TX write data.
- `tx_wr` input 1: TX write strobe.
- `tx_full` output 1: TX FIFO full.
- `rx_rdata` output 8: RX FIFO head (show-ahead).
- `rx_rd` input 1: RX pop strobe.
- `rx_empty` output 1: RX FIFO empty.
- `clr_flags` input 1: clears `tx_underrun` and `rx_overrun`.
- `tx_underrun` output 1: sticky; a fill byte was shifted out.
- `rx_overrun` output 1: sticky; a received byte was dropped.
- `frame_done` output 1: one-cycle pulse at frame end.
- `frame_len` output 8: bytes in the last frame, saturating at 255.
- `ssn` input 1: slave select, shared with `spi_slave`. Asynchronous to `clk`.
- `tr_done_s` input 1: byte-done pulse from `spi_slave`.
- `data_r_s` input 8: received byte from `spi_slave`.
- `data_s` output 8: transmit byte to `spi_slave`.
- `spcon_s` output 8: config to `spi_slave`, laid out as {5'b0, cpol, cpha, en}.

## Operation
- `ssn` passes through a 2-FF synchronizer (reset value 1) to give `ssn_s`.
- State machine has three states: IDLE, ACTIVE, END.
  - IDLE -> ACTIVE when `ssn_s`=0 and the latched enable is 1. Clears the byte counter.
  - ACTIVE -> END when `ssn_s`=1.
  - END -> IDLE unconditionally after 1 cycle. `frame_done`=1 in END, and `frame_len` takes the counter value.
- `spcon_s[2:0]` reloads from `cfg_*` only in IDLE. Config changes made during ACTIVE or END take effect after the frame.
- `cur_valid` flag means `data_s` holds real TX data.
  - In IDLE: if `cur_valid`=0 and TX is non-empty, load `data_s` from the TX head, pop, and set `cur_valid`=1.
- On `tr_done_s`=1 in ACTIVE:
  - If `cur_valid`=0, set `tx_underrun`.
  - Load the next TX byte into `data_s` (pop, `cur_valid`=1). If TX is empty, load `FILL_BYTE` instead and set `cur_valid`=0.
  - Push `data_r_s` into RX. If RX is full and `rx_rd`=0, drop the byte and set `rx_overrun`.
  - Increment the byte counter, saturating at 255.
- `tr_done_s` is ignored in IDLE and END, and whenever the latched enable is 0.
- TX write when full: ignored, no flag. TX write while the TX FIFO is empty and a pop is requested: the write lands and the pop does nothing.
- RX push while full with `rx_rd` in the same cycle: both happen, count unchanged, no overrun.
- `rx_rd` when empty: ignored.
- Flag priority: a set event beats `clr_flags` in the same cycle.
- Pointers are log2(`FIFO_DEPTH`) bits plus a wrap bit.
  - Full = equal pointer indices with differing wrap bits.
  - Empty = pointers fully equal.

## Timing
- Reset values:
  - `data_s`=`FILL_BYTE`.
  - `spcon_s`=8'h00.
  - `cur_valid`=0.
  - `tx_full`=0, `rx_empty`=1.
  - `rx_rdata`=8'h00.
  - `tx_underrun`=`rx_overrun`=0.
  - `frame_done`=0, `frame_len`=0.
  - State=IDLE.
- Reset mid-frame: immediately aborts the frame, empties both FIFOs, and emits no `frame_done`.
- `tr_done_s` high at edge n: new `data_s`, RX push and counter update are all visible at n+1.
- `rx_empty` falls 1 cycle after the push edge. `rx_rdata` is valid whenever `rx_empty`=0.
- TX write at edge n: `tx_full` and the IDLE preload can act at n+1.
- `ssn` falls at edge n: ACTIVE no earlier than n+2; `spcon_s` is frozen from n+2.
- `ssn` rises: END 2-3 cycles later. `frame_done` lasts exactly 1 cycle, and `frame_len` holds until the next END.
- The `tr_done_s` for the last byte always arrives while `ssn_s`=0 and is counted.

## Test plan
- Basic frame: write A5, 3C into TX, enable with cpol=0, cpha=0, run a 2-byte frame with master sending 11, 22. Expect:
  - 11, 22 in RX.
  - `frame_done` pulse with `frame_len`=2.
  - `data_s`=`FILL_BYTE` at the end.
  - No flags set.
- Underrun: TX holds 1 byte (5A), run a 3-byte frame. Expect:
  - `data_s` shows 5A, then FF, FF.
  - `tx_underrun`=1 after the second `tr_done_s`.
  - `frame_len`=3.
- Overrun: RX is never read, run a (`FIFO_DEPTH`+1)-byte frame. Expect:
  - RX holds the first 4 bytes.
  - `rx_overrun`=1 at the 5th `tr_done_s`.
  - Pulsing `clr_flags` afterwards clears it.
- Config freeze: change cfg to cpol=1, cpha=1 during ACTIVE. Expect `spcon_s` to stay 8'h01 until IDLE, then become 8'h07.
- Simultaneous events:
  - RX full with `rx_rd` and `tr_done_s` in the same cycle: no overrun, count stays 4.
  - `clr_flags` together with an underrun event: flag stays 1.
- Async reset: assert `rst_n` low mid-byte. Expect all outputs at their reset values the same cycle and no `frame_done` after release.
